// File: rtl/prot_shutdown_seq.sv
// Protection shutdown sequencer: blocks PWM on faults, commands the bypass
// switch when requested and supervises its closed confirmation.
// Optional build macro SEQ_FIBER_AUTOBYP_EN adds a fiber-fault persistence
// counter that forces bypass after FIBER_BYP_US of continuous fiber fault.
module prot_shutdown_seq #(
  parameter int unsigned T_DEAD_US    = 10,
  parameter int unsigned T_BYP_TMO_US = 2000,
  parameter int unsigned FIBER_BYP_US = 1000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       time_1us,
  input  logic       start_stop,
  input  logic       err_unit,
  input  logic       fiber_err,
  input  logic       reset_unit,
  input  logic       BypConRx,
  input  logic       BypOk_filt,
  output logic       pwm_block,
  output logic       BypCon,
  output logic       byp_fail,
  output logic [2:0] seq_state
);

  localparam int unsigned CNT_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(T_DEAD_US);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(T_BYP_TMO_US);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_BLOCK    = 3'd2,
    S_BYP_WAIT = 3'd3,
    S_BYPASSED = 3'd4,
    S_BYP_FAIL = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_byp_req;
  logic             w_byp_req_nxt;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_tmo;
  logic             w_fiber_trig;
  logic             w_byp_set;
  logic             w_pwm_block_nxt;
  logic             w_byp_con_nxt;
  logic             w_byp_fail_nxt;

`ifdef SEQ_FIBER_AUTOBYP_EN
  localparam logic [CNT_W-1:0] FIBER_LIM = CNT_W'(FIBER_BYP_US);
  logic [CNT_W-1:0] r_fiber_cnt;

  // Continuous fiber-fault duration; any fault-free cycle restarts it
  always_ff @(posedge clk) begin
    if (Reset || !fiber_err) begin
      r_fiber_cnt <= '0;
    end else if (time_1us && (r_fiber_cnt != CNT_MAX)) begin
      r_fiber_cnt <= r_fiber_cnt + CNT_W'(1);
    end
  end

  assign w_fiber_trig = (r_fiber_cnt >= FIBER_LIM);
`else
  // No persistence counter in this build; constant 0 for any legal FIBER_BYP_US
  assign w_fiber_trig = (FIBER_BYP_US == 32'd0);
`endif

  assign w_byp_set = BypConRx | w_fiber_trig;

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, bypass-request and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_byp_req_nxt = r_byp_req;
    case (r_state)
      S_IDLE: begin
        if (BypConRx) begin
          w_state_nxt   = S_BLOCK;
          w_byp_req_nxt = 1'b1;
        end else if (start_stop && !err_unit && !fiber_err) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (err_unit || fiber_err || BypConRx) begin
          w_state_nxt = S_BLOCK;
          if (BypConRx) begin
            w_byp_req_nxt = 1'b1;
          end
        end else if (!start_stop) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BLOCK: begin
        if (w_byp_set) begin
          w_byp_req_nxt = 1'b1;
        end
        if (r_byp_req && (r_dwell >= DEAD_LIM)) begin
          w_state_nxt = S_BYP_WAIT;
        end else if (reset_unit && !err_unit && !fiber_err && !r_byp_req && !w_byp_set) begin
          w_state_nxt   = S_IDLE;
          w_byp_req_nxt = 1'b0;
        end
      end
      S_BYP_WAIT: begin
        if (BypOk_filt) begin
          w_state_nxt = S_BYPASSED;
        end else if (r_tmo >= TMO_LIM) begin
          w_state_nxt = S_BYP_FAIL;
        end
      end
      S_BYPASSED, S_BYP_FAIL: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt   = S_BLOCK;
        w_byp_req_nxt = 1'b0;
      end
    endcase

    w_pwm_block_nxt = (w_state_nxt != S_RUN);
    w_byp_con_nxt   = (w_state_nxt == S_BYP_WAIT) || (w_state_nxt == S_BYPASSED) ||
                      (w_state_nxt == S_BYP_FAIL);
    w_byp_fail_nxt  = (w_state_nxt == S_BYP_FAIL);
  end

  // Latched bypass request
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_byp_req <= 1'b0;
    end else begin
      r_byp_req <= w_byp_req_nxt;
    end
  end

  // PWM-blocked dwell timer, restarted on every entry to BLOCK
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_dwell <= '0;
    end else if ((w_state_nxt == S_BLOCK) && (r_state != S_BLOCK)) begin
      r_dwell <= '0;
    end else if ((r_state == S_BLOCK) && time_1us && (r_dwell != CNT_MAX)) begin
      r_dwell <= r_dwell + CNT_W'(1);
    end
  end

  // Bypass confirmation timeout, restarted on every entry to BYP_WAIT
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_tmo <= '0;
    end else if ((w_state_nxt == S_BYP_WAIT) && (r_state != S_BYP_WAIT)) begin
      r_tmo <= '0;
    end else if ((r_state == S_BYP_WAIT) && time_1us && (r_tmo != CNT_MAX)) begin
      r_tmo <= r_tmo + CNT_W'(1);
    end
  end

  // Registered outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (Reset) begin
      pwm_block <= 1'b1;
      BypCon    <= 1'b0;
      byp_fail  <= 1'b0;
      seq_state <= 3'd0;
    end else begin
      pwm_block <= w_pwm_block_nxt;
      BypCon    <= w_byp_con_nxt;
      byp_fail  <= w_byp_fail_nxt;
      seq_state <= 3'(w_state_nxt);
    end
  end

endmodule

// File: tb/tb_prot_shutdown_seq.sv
// Self-checking bench for prot_shutdown_seq: directed scenarios plus random
// input segments, every cycle compared against a behavioural model.
module tb_prot_shutdown_seq;

  localparam int T_DEAD = 10;
  localparam int T_TMO  = 2000;
  localparam int T_FIB  = 1000;
  localparam int SAT    = 16383;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_BLOCK = 2, ST_WAIT = 3, ST_BYPD = 4, ST_FAIL = 5;

`ifdef SEQ_FIBER_AUTOBYP_EN
  localparam bit FIB_EN = 1'b1;
`else
  localparam bit FIB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       time_1us = 1'b0;
  logic       start_stop = 1'b0;
  logic       err_unit = 1'b0;
  logic       fiber_err = 1'b0;
  logic       reset_unit = 1'b0;
  logic       BypConRx = 1'b0;
  logic       BypOk_filt = 1'b0;
  logic       pwm_block;
  logic       BypCon;
  logic       byp_fail;
  logic [2:0] seq_state;

  always #5 clk = ~clk;

  prot_shutdown_seq #(
    .T_DEAD_US   (T_DEAD),
    .T_BYP_TMO_US(T_TMO),
    .FIBER_BYP_US(T_FIB)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .time_1us  (time_1us),
    .start_stop(start_stop),
    .err_unit  (err_unit),
    .fiber_err (fiber_err),
    .reset_unit(reset_unit),
    .BypConRx  (BypConRx),
    .BypOk_filt(BypOk_filt),
    .pwm_block (pwm_block),
    .BypCon    (BypCon),
    .byp_fail  (byp_fail),
    .seq_state (seq_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int phase    = 0;

  // reference model: current mode, bypass request and microsecond counts
  int m_state = ST_IDLE;
  bit m_req   = 1'b0;
  int m_dwell = 0;
  int m_tmo   = 0;
  int m_fib   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock, using the inputs seen at the edge
  task automatic model_step();
    bit trig;
    bit req_now;
    if (Reset) begin
      m_state = ST_IDLE; m_req = 0; m_dwell = 0; m_tmo = 0; m_fib = 0;
      return;
    end
    trig = FIB_EN && (m_fib >= T_FIB);
    case (m_state)
      ST_IDLE: begin
        if (BypConRx) begin m_state = ST_BLOCK; m_req = 1; m_dwell = 0; end
        else if (start_stop && !err_unit && !fiber_err) m_state = ST_RUN;
      end
      ST_RUN: begin
        if (err_unit || fiber_err || BypConRx) begin
          m_state = ST_BLOCK; m_dwell = 0;
          if (BypConRx) m_req = 1;
        end else if (!start_stop) m_state = ST_IDLE;
      end
      ST_BLOCK: begin
        req_now = m_req || BypConRx || trig;
        if (m_req && m_dwell >= T_DEAD) begin
          m_state = ST_WAIT; m_tmo = 0;
        end else if (reset_unit && !err_unit && !fiber_err && !req_now) begin
          m_state = ST_IDLE; req_now = 0;
        end else if (time_1us && m_dwell < SAT) m_dwell++;
        m_req = req_now;
      end
      ST_WAIT: begin
        if (BypOk_filt) m_state = ST_BYPD;
        else if (m_tmo >= T_TMO) m_state = ST_FAIL;
        else if (time_1us && m_tmo < SAT) m_tmo++;
      end
      default: ;
    endcase
    if (!fiber_err) m_fib = 0;
    else if (time_1us && m_fib < SAT) m_fib++;
  endtask

  function automatic int exp_vec();
    int pwm, bc, fl;
    pwm = (m_state != ST_RUN) ? 1 : 0;
    bc  = (m_state >= ST_WAIT) ? 1 : 0;
    fl  = (m_state == ST_FAIL) ? 1 : 0;
    return pwm * 32 + bc * 16 + fl * 8 + m_state;
  endfunction

  // One clock: 1 us strobe every 4th cycle, model update, output compare
  task automatic step();
    time_1us = (phase == 3);
    phase = (phase + 1) % 4;
    if (time_1us) n_strobe++;
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", int'({pwm_block, BypCon, byp_fail, seq_state}), exp_vec());
  endtask

  task automatic clear_inputs();
    start_stop = 0; err_unit = 0; fiber_err = 0; reset_unit = 0;
    BypConRx = 0; BypOk_filt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    step();
    step();
    Reset = 0;
  endtask

  task automatic wait_state(input int target, input int max_cyc, input string tag);
    int k;
    k = 0;
    while (int'(seq_state) != target && k < max_cyc) begin
      step();
      k++;
    end
    chk(tag, int'(seq_state), target);
  endtask

  task automatic run_strobes(input int n);
    int s;
    s = n_strobe;
    while (n_strobe - s < n) step();
  endtask

  initial begin
    int s;
    int hold;

    // reset values
    do_reset();
    chk("rst_pwm", pwm_block, 1);
    chk("rst_bypcon", BypCon, 0);
    chk("rst_fail", byp_fail, 0);
    chk("rst_state", seq_state, 0);

    // start -> RUN, unit fault -> BLOCK
    start_stop = 1; step();
    chk("run_state", seq_state, ST_RUN);
    chk("run_pwm", pwm_block, 0);
    err_unit = 1; step();
    chk("err_state", seq_state, ST_BLOCK);
    chk("err_pwm", pwm_block, 1);

    // fault reset clears BLOCK only when no fault is present
    err_unit = 0; reset_unit = 1; step();
    chk("clr_idle", seq_state, ST_IDLE);
    reset_unit = 0; step();
    chk("rerun", seq_state, ST_RUN);
    err_unit = 1; step();
    reset_unit = 1; step(); step();
    chk("clr_fault_wins", seq_state, ST_BLOCK);
    clear_inputs();

    // bypass command: dead time, confirmation, terminal state
    do_reset();
    start_stop = 1; step();
    BypConRx = 1; step(); BypConRx = 0;
    chk("byp_block", seq_state, ST_BLOCK);
    s = n_strobe;
    wait_state(ST_WAIT, 200, "byp_wait");
    chk("dead_us", n_strobe - s, T_DEAD);
    chk("byp_con", BypCon, 1);
    chk("byp_pwm", pwm_block, 1);
    run_strobes(500);
    BypOk_filt = 1; step();
    chk("bypassed", seq_state, ST_BYPD);
    BypOk_filt = 0; reset_unit = 1; start_stop = 0; BypConRx = 1;
    repeat (20) step();
    chk("byp_terminal", seq_state, ST_BYPD);
    chk("byp_term_con", BypCon, 1);
    chk("byp_term_fail", byp_fail, 0);

    // confirmation timeout
    do_reset();
    start_stop = 1; step();
    BypConRx = 1; step(); BypConRx = 0;
    wait_state(ST_WAIT, 200, "tmo_wait");
    s = n_strobe;
    wait_state(ST_FAIL, 9000, "tmo_fail_state");
    chk("tmo_us", n_strobe - s, T_TMO);
    chk("tmo_fail", byp_fail, 1);
    chk("tmo_con", BypCon, 1);
    Reset = 1; start_stop = 1; BypConRx = 1; step(); Reset = 0; clear_inputs();
    chk("tmo_rst_state", seq_state, 0);
    chk("tmo_rst_pwm", pwm_block, 1);
    chk("tmo_rst_con", BypCon, 0);
    chk("tmo_rst_fail", byp_fail, 0);

    // persistent fiber fault
    do_reset();
    start_stop = 1; step();
`ifdef SEQ_FIBER_AUTOBYP_EN
    fiber_err = 1;
    s = n_strobe;
    step();
    chk("fib_block", seq_state, ST_BLOCK);
    wait_state(ST_WAIT, 5000, "fib_wait");
    chk("fib_us", n_strobe - s, T_FIB);
    do_reset();
    start_stop = 1; step();
    fiber_err = 1;
    run_strobes(T_FIB - 1);
    fiber_err = 0;
    repeat (400) step();
    fiber_err = 1;
    run_strobes(T_FIB - 1);
    fiber_err = 0;
    repeat (40) step();
    chk("fib_short_state", seq_state, ST_BLOCK);
    chk("fib_short_con", BypCon, 0);
`else
    fiber_err = 1;
    run_strobes(5000);
    chk("fib_off_state", seq_state, ST_BLOCK);
    chk("fib_off_con", BypCon, 0);
`endif

    // random segments against the model
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      Reset      = ($urandom_range(0, 19) == 0) ||
                   (m_state >= ST_BYPD && $urandom_range(0, 3) == 0);
      start_stop = $urandom_range(0, 1) == 1;
      err_unit   = $urandom_range(0, 3) == 0;
      fiber_err  = $urandom_range(0, 3) == 0;
      reset_unit = $urandom_range(0, 1) == 1;
      BypConRx   = $urandom_range(0, 15) == 0;
      BypOk_filt = $urandom_range(0, 7) == 0;
      hold = Reset ? 1 : $urandom_range(1, 60);
      repeat (hold) step();
    end
    Reset = 0;
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prot_shutdown_seq.md
PROT_SHUTDOWN_SEQ -- requirements
Module: prot_shutdown_seq

Interface
REQ-001 SHALL have parameter T_DEAD_US, default 10, meaning PWM-blocked dwell before bypass command, in us, range 1..16383.
REQ-002 SHALL have parameter T_BYP_TMO_US, default 2000, meaning max wait for bypass-closed confirmation, in us, range 1..16383.
REQ-003 SHALL have parameter FIBER_BYP_US, default 1000, meaning continuous fiber fault duration that forces bypass, in us, range 1..16383.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 time_1us  input  1  one-cycle strobe every 1 us.
REQ-007 start_stop  input  1  run command from fiber receiver, level.
REQ-008 err_unit  input  1  local unit fault, level.
REQ-009 fiber_err  input  1  fiber delay or verify fault, level.
REQ-010 reset_unit  input  1  fault-reset command, level.
REQ-011 BypConRx  input  1  bypass command from fiber receiver, level.
REQ-012 BypOk_filt  input  1  debounced bypass-closed confirmation, level.
REQ-013 pwm_block  output  1  1 = force all four IGBT drives off.
REQ-014 BypCon  output  1  bypass switch close command.
REQ-015 byp_fail  output  1  bypass confirmation timeout.
REQ-016 seq_state  output  3  state code: IDLE=0, RUN=1, BLOCK=2, BYP_WAIT=3, BYPASSED=4, BYP_FAIL=5.

Function
REQ-017 All outputs SHALL be registered; state change SHALL be visible on outputs one clk after the sampled cause.
REQ-018 IDLE: pwm_block=1; to RUN when start_stop=1 and err_unit=0 and fiber_err=0; to BLOCK with byp_req set when BypConRx=1 (BypConRx has priority).
REQ-019 RUN: pwm_block=0; to BLOCK on err_unit|fiber_err|BypConRx (byp_req set if BypConRx); else to IDLE on start_stop=0.
REQ-020 BLOCK: pwm_block=1; 14-bit dwell counter cleared on entry, incremented on time_1us, saturating at 16383.
REQ-021 BLOCK: byp_req SHALL latch on BypConRx=1 or fiber-persist trigger (REQ-025); to BYP_WAIT when byp_req=1 and dwell >= T_DEAD_US.
REQ-022 BLOCK: to IDLE when reset_unit=1, err_unit=0, fiber_err=0, byp_req=0; a fault present in the same cycle as reset_unit SHALL win (stay in BLOCK).
REQ-023 BYP_WAIT: pwm_block=1, BypCon=1; timeout counter cleared on entry, incremented on time_1us; to BYPASSED on BypOk_filt=1; else to BYP_FAIL when count reaches T_BYP_TMO_US; BypOk_filt and timeout in same cycle -> BYPASSED.
REQ-024 BYPASSED and BYP_FAIL: terminal; pwm_block=1, BypCon=1; byp_fail=1 in BYP_FAIL only; reset_unit, start_stop, BypConRx ignored; exit only via Reset.
REQ-025 Fiber-persist counter: 14 bits, increments on time_1us while fiber_err=1, clears in the cycle fiber_err=0, saturates; trigger when count >= FIBER_BYP_US.
REQ-026 byp_req SHALL clear only on Reset or on BLOCK->IDLE transition.
REQ-027 Undefined seq_state encodings SHALL recover to BLOCK with byp_req=0.

Reset
REQ-028 On Reset=1 at a clk edge: state=IDLE, pwm_block=1, BypCon=0, byp_fail=0, seq_state=0, byp_req=0, all counters=0.
REQ-029 Reset SHALL take effect from any state including BYP_WAIT and terminal states, overriding all other inputs in that cycle.

Configuration
REQ-030 Macro SEQ_FIBER_AUTOBYP_EN defined: fiber-persist counter and trigger (REQ-025) implemented; persistent fiber fault forces bypass.
REQ-031 Macro SEQ_FIBER_AUTOBYP_EN undefined: counter SHALL not be synthesized; byp_req set only by BypConRx; fiber_err still causes RUN->BLOCK.

Verification
REQ-032 Reset, start_stop=1 -> seq_state 0->1, pwm_block 0 one clk later; err_unit=1 -> pwm_block=1 and seq_state=2 next clk.
REQ-033 In BLOCK, err_unit=0 and reset_unit=1 -> IDLE; repeat with err_unit=1 in same cycle -> stays BLOCK.
REQ-034 RUN, BypConRx pulse 1 clk -> BLOCK, BYP_WAIT after 10 us, BypCon=1; BypOk_filt=1 at 500 us -> BYPASSED; reset_unit ignored.
REQ-035 BYP_WAIT with BypOk_filt=0 -> BYP_FAIL and byp_fail=1 exactly 2000 time_1us strobes after entry; Reset -> all outputs at reset values.
REQ-036 With SEQ_FIBER_AUTOBYP_EN, fiber_err=1 for 1000 us -> BYP_WAIT; fiber_err drop at 999 us -> counter clears, no bypass; without macro, fiber_err 5000 us -> stays BLOCK, BypCon=0.
